axi2apb_ctrl: RTL

- Consumer end of the axi2apb command FIFO.
- Pops one queued AXI command at a time and runs the matching APB transfer, taking write data from the AXI W channel.
- Returns the AXI R or B response and pulses finish_rd or finish_wr so the command side pops the entry.
- Sits between the command block, the AXI W/R/B channels and the APB bus.

---
 rtl/axi2apb_ctrl_pkg.sv | 24 ++
 rtl/axi2apb_ctrl_if.sv | 78 +++++++
 rtl/axi2apb_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axi2apb_ctrl_pkg.sv
// Shared definitions for the axi2apb command consumer: FSM encoding,
// AXI response codes and the fixed 32-bit data path geometry.
package axi2apb_ctrl_pkg;

  localparam int DATA_BITS = 32;
  localparam int STRB_BITS = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_W = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Map the APB slave error flag onto an AXI xRESP code.
  function automatic logic [1:0] apb_resp(input logic slverr);
    return slverr ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi2apb_ctrl_if.sv
// Bundle of the command-FIFO head, AXI W/R/B channels and APB bus seen by
// the axi2apb controller. The controller uses the master modport (it is the
// APB master); the surrounding logic or a bench uses the slave modport.
interface axi2apb_ctrl_if
  import axi2apb_ctrl_pkg::*;
#(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 24
);

  // Command FIFO head
  logic                 cmd_empty;
  logic                 cmd_read;
  logic [ID_BITS-1:0]   cmd_id;
  logic [ADDR_BITS-1:0] cmd_addr;
  logic                 cmd_err;
  logic                 finish_wr;
  logic                 finish_rd;

  // AXI write data
  logic [DATA_BITS-1:0] WDATA;
  logic [STRB_BITS-1:0] WSTRB;
  logic                 WLAST;
  logic                 WVALID;
  logic                 WREADY;

  // AXI write response
  logic [ID_BITS-1:0]   BID;
  logic [1:0]           BRESP;
  logic                 BVALID;
  logic                 BREADY;

  // AXI read data
  logic [ID_BITS-1:0]   RID;
  logic [DATA_BITS-1:0] RDATA;
  logic [1:0]           RRESP;
  logic                 RLAST;
  logic                 RVALID;
  logic                 RREADY;

  // APB
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [ADDR_BITS-1:0] paddr;
  logic [DATA_BITS-1:0] pwdata;
  logic [STRB_BITS-1:0] pstrb;
  logic [DATA_BITS-1:0] prdata;
  logic                 pready;
  logic                 pslverr;

  modport master (
    input  cmd_empty, cmd_read, cmd_id, cmd_addr, cmd_err,
    output finish_wr, finish_rd,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_empty, cmd_read, cmd_id, cmd_addr, cmd_err,
    input  finish_wr, finish_rd,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/axi2apb_ctrl.sv
// axi2apb controller: pops one command at a time from the command FIFO,
// runs the APB transfer (taking write data from AXI W), returns the AXI R or
// B response and pulses finish_rd/finish_wr on the response handshake.
module axi2apb_ctrl
  import axi2apb_ctrl_pkg::*;
#(
  parameter int ID_BITS   = 4,
  parameter int ADDR_BITS = 24
) (
  input  logic           clk,
  input  logic           reset,
  axi2apb_ctrl_if.master bus
);

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_BITS-1:0]  paddr_q, paddr_d;
  logic [DATA_BITS-1:0]  pwdata_q, pwdata_d;
  logic [STRB_BITS-1:0]  pstrb_q, pstrb_d;
  logic [DATA_BITS-1:0]  rdata_q, rdata_d;
  logic [ID_BITS-1:0]    rid_q, rid_d;
  logic [ID_BITS-1:0]    bid_q, bid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic                  bvalid_q, bvalid_d;
  // Direction and error flag of the command in flight.
  logic                  is_read_q, is_read_d;
  logic                  err_q, err_d;
  // Set for the one IDLE cycle after a pop so the FIFO head can advance
  // before it is looked at again.
  logic                  hold_q, hold_d;

  logic                  finish_rd;
  logic                  finish_wr;
  logic                  unused_wlast;

  // Single-beat commands only, so the W channel's last flag carries no info.
  assign unused_wlast = bus.WLAST;

  assign finish_rd = rvalid_q & bus.RREADY;
  assign finish_wr = bvalid_q & bus.BREADY;

  // Next-state and holding-register update for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    rid_d     = rid_q;
    bid_d     = bid_q;
    rresp_d   = rresp_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    bvalid_d  = bvalid_q;
    is_read_d = is_read_q;
    err_d     = err_q;
    hold_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!hold_q && !bus.cmd_empty) begin
          is_read_d = bus.cmd_read;
          err_d     = bus.cmd_err;
          if (!bus.cmd_err) begin
            paddr_d  = bus.cmd_addr;
            pwrite_d = ~bus.cmd_read;
          end
          if (bus.cmd_read) begin
            rid_d = bus.cmd_id;
            if (bus.cmd_err) begin
              // Unsupported read: answer immediately, never touch APB.
              rdata_d  = '0;
              rresp_d  = RESP_SLVERR;
              rvalid_d = 1'b1;
              state_d  = ST_RESP;
            end else begin
              pstrb_d = '0;
              psel_d  = 1'b1;
              state_d = ST_SETUP;
            end
          end else begin
            // Writes always wait for their W beat, even when unsupported.
            bid_d   = bus.cmd_id;
            state_d = ST_WAIT_W;
          end
        end
      end

      ST_WAIT_W: begin
        if (bus.WVALID) begin
          pwdata_d = bus.WDATA;
          pstrb_d  = bus.WSTRB;
          if (err_q) begin
            bresp_d  = RESP_SLVERR;
            bvalid_d = 1'b1;
            state_d  = ST_RESP;
          end else begin
            psel_d  = 1'b1;
            state_d = ST_SETUP;
          end
        end
      end

      ST_SETUP: begin
        // pready is not looked at here; SETUP is always exactly one cycle.
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (bus.pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (is_read_q) begin
            rdata_d  = bus.prdata;
            rresp_d  = apb_resp(bus.pslverr);
            rvalid_d = 1'b1;
          end else begin
            bresp_d  = apb_resp(bus.pslverr);
            bvalid_d = 1'b1;
          end
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        if (finish_rd) begin
          rvalid_d = 1'b0;
          hold_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (finish_wr) begin
          bvalid_d = 1'b0;
          hold_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
        rvalid_d  = 1'b0;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      rid_q     <= '0;
      bid_q     <= '0;
      rresp_q   <= '0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      is_read_q <= 1'b0;
      err_q     <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      rid_q     <= rid_d;
      bid_q     <= bid_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      bvalid_q  <= bvalid_d;
      is_read_q <= is_read_d;
      err_q     <= err_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.finish_rd = finish_rd;
  assign bus.finish_wr = finish_wr;

  assign bus.WREADY    = (state_q == ST_WAIT_W);

  assign bus.BID       = bid_q;
  assign bus.BRESP     = bresp_q;
  assign bus.BVALID    = bvalid_q;

  assign bus.RID       = rid_q;
  assign bus.RDATA     = rdata_q;
  assign bus.RRESP     = rresp_q;
  assign bus.RLAST     = rvalid_q;
  assign bus.RVALID    = rvalid_q;

  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.pstrb     = pstrb_q;

endmodule
